// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake: head-of-queue entry and decode back-pressure.
interface fetch_unit_if;
  logic        dec_ready;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic        f_exc_en;
  logic [3:0]  f_exc_code;
  logic [63:0] f_exc_val;

  // Fetch side drives the head entry, decode side drives ready
  modport master (
    input  dec_ready,
    output f_valid, f_pc, f_instr, f_exc_en, f_exc_code, f_exc_val
  );

  modport slave (
    output dec_ready,
    input  f_valid, f_pc, f_instr, f_exc_en, f_exc_code, f_exc_val
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC generation, fetch queue, exception halt and redirect.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [63:0]         imem_pc,
  input  logic [31:0]         imem_instr,
  input  logic                imem_exc_en,
  input  logic [3:0]          imem_exc_code,
  input  logic [63:0]         imem_exc_val,
  input  logic                redirect_en,
  input  logic [63:0]         redirect_pc,
  fetch_unit_if.master        fif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {S_FETCH, S_HALT} state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } entry_t;

  localparam entry_t OUT_RESET = '{pc: 64'h0, instr: NOP_INSTR, exc_en: 1'b0,
                                   exc_code: 4'h0, exc_val: 64'h0};

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             f_valid_q, f_valid_d;
  entry_t           out_q, out_d;
  entry_t           mem_q [DEPTH];

  logic             pop;
  logic             push;
  logic [CNT_W-1:0] remaining;
  entry_t           new_entry;

  // Build the entry for the current PC; misalignment outranks a memory fault
  always_comb begin
    new_entry.pc       = pc_q;
    new_entry.instr    = imem_instr;
    new_entry.exc_en   = 1'b0;
    new_entry.exc_code = 4'h0;
    new_entry.exc_val  = 64'h0;
    if (pc_q[1:0] != 2'b00) begin
      new_entry.instr    = NOP_INSTR;
      new_entry.exc_en   = 1'b1;
      new_entry.exc_code = 4'h0;
      new_entry.exc_val  = pc_q;
    end else if (imem_exc_en) begin
      new_entry.instr    = NOP_INSTR;
      new_entry.exc_en   = 1'b1;
      new_entry.exc_code = imem_exc_code;
      new_entry.exc_val  = imem_exc_val;
    end
  end

  // Queue control, PC update, FSM and next head-entry output
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    f_valid_d = f_valid_q;
    out_d     = out_q;

    pop       = f_valid_q & fif.dec_ready & ~redirect_en;
    push      = (state_q == S_FETCH) & ~redirect_en & ((count_q != DEPTH_C) | pop);
    remaining = count_q - CNT_W'(pop);

    if (redirect_en) begin
      // Redirect flushes everything; output fields keep their last values
      state_d   = S_FETCH;
      pc_d      = redirect_pc;
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      f_valid_d = 1'b0;
    end else begin
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
        if (new_entry.exc_en) begin
          state_d = S_HALT;
        end else begin
          pc_d = pc_q + 64'd4;
        end
      end
      count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
      f_valid_d = (count_d != '0);
      // Head after this edge is either an older queued entry or the one being pushed
      if (remaining != '0) begin
        out_d = mem_q[head_d];
      end else if (push) begin
        out_d = new_entry;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      f_valid_q <= 1'b0;
      out_q     <= OUT_RESET;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      f_valid_q <= f_valid_d;
      out_q     <= out_d;
    end
  end

  // Queue storage; only slots between head and tail are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= new_entry;
    end
  end

  assign imem_pc        = pc_q;
  assign fif.f_valid    = f_valid_q;
  assign fif.f_pc       = out_q.pc;
  assign fif.f_instr    = out_q.instr;
  assign fif.f_exc_en   = out_q.exc_en;
  assign fif.f_exc_code = out_q.exc_code;
  assign fif.f_exc_val  = out_q.exc_val;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_pc;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        exc_arm;

  int pass_cnt;
  int total_cnt;

  fetch_unit_if fif ();

  fetch_unit u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .imem_exc_en   (imem_exc_en),
    .imem_exc_code (imem_exc_code),
    .imem_exc_val  (imem_exc_val),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .fif           (fif)
  );

  // Memory model: distinct word per address, one faulting address when armed
  assign imem_instr    = {16'hC0DE, imem_pc[15:0]};
  assign imem_exc_en   = exc_arm && (imem_pc == 64'h2000);
  assign imem_exc_code = 4'h1;
  assign imem_exc_val  = 64'h2000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 64'h0;
    exc_arm     = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; redirect_en = 1'b0; redirect_pc = 64'h0; exc_arm = 1'b0;
    fif.dec_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    if (fif.f_valid !== 1'b0) $display("FAIL rst_valid got %h exp %h", fif.f_valid, 1'b0); else pass_cnt++;
    total_cnt++;
    if (imem_pc !== 64'h0) $display("FAIL rst_pc got %h exp %h", imem_pc, 64'h0); else pass_cnt++;
    total_cnt++;
    if (fif.f_instr !== 32'h13) $display("FAIL rst_instr got %h exp %h", fif.f_instr, 32'h13); else pass_cnt++;
    total_cnt++;
    if ({fif.f_pc, fif.f_exc_en, fif.f_exc_code, fif.f_exc_val} !== 133'h0)
      $display("FAIL rst_fields got %h exp 0", {fif.f_pc, fif.f_exc_en, fif.f_exc_code, fif.f_exc_val});
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_stream();
    fif.dec_ready = 1'b1;
    do_reset();
    tick();
    if (fif.f_valid !== 1'b1) $display("FAIL stream_valid got %h exp %h", fif.f_valid, 1'b1); else pass_cnt++;
    total_cnt++;
    if (fif.f_pc !== 64'h0) $display("FAIL stream_pc0 got %h exp %h", fif.f_pc, 64'h0); else pass_cnt++;
    total_cnt++;
    if (fif.f_instr !== 32'hC0DE0000) $display("FAIL stream_instr0 got %h exp %h", fif.f_instr, 32'hC0DE0000); else pass_cnt++;
    total_cnt++;
    tick();
    if (fif.f_pc !== 64'h4) $display("FAIL stream_pc4 got %h exp %h", fif.f_pc, 64'h4); else pass_cnt++;
    total_cnt++;
    tick();
    if (fif.f_pc !== 64'h8) $display("FAIL stream_pc8 got %h exp %h", fif.f_pc, 64'h8); else pass_cnt++;
    total_cnt++;
    tick();
    if (fif.f_pc !== 64'hC) $display("FAIL stream_pc12 got %h exp %h", fif.f_pc, 64'hC); else pass_cnt++;
    total_cnt++;
    if (fif.f_instr !== 32'hC0DE000C) $display("FAIL stream_instr12 got %h exp %h", fif.f_instr, 32'hC0DE000C); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_stall_and_full();
    fif.dec_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    if (fif.f_valid !== 1'b1) $display("FAIL stall_valid got %h exp %h", fif.f_valid, 1'b1); else pass_cnt++;
    total_cnt++;
    if (fif.f_pc !== 64'h0) $display("FAIL stall_head got %h exp %h", fif.f_pc, 64'h0); else pass_cnt++;
    total_cnt++;
    if (imem_pc !== 64'h8) $display("FAIL stall_imem_pc got %h exp %h", imem_pc, 64'h8); else pass_cnt++;
    total_cnt++;
    fif.dec_ready = 1'b1;
    tick();
    if (fif.f_pc !== 64'h4) $display("FAIL drain_pc4 got %h exp %h", fif.f_pc, 64'h4); else pass_cnt++;
    total_cnt++;
    if (imem_pc !== 64'hC) $display("FAIL full_push_pop got %h exp %h", imem_pc, 64'hC); else pass_cnt++;
    total_cnt++;
    tick();
    if (fif.f_pc !== 64'h8) $display("FAIL drain_pc8 got %h exp %h", fif.f_pc, 64'h8); else pass_cnt++;
    total_cnt++;
    if (imem_pc !== 64'h10) $display("FAIL full_throughput got %h exp %h", imem_pc, 64'h10); else pass_cnt++;
    total_cnt++;
    tick();
    if (fif.f_pc !== 64'hC) $display("FAIL drain_pc12 got %h exp %h", fif.f_pc, 64'hC); else pass_cnt++;
    total_cnt++;
    if (fif.f_instr !== 32'hC0DE000C) $display("FAIL drain_instr12 got %h exp %h", fif.f_instr, 32'hC0DE000C); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_redirect();
    fif.dec_ready = 1'b0;
    do_reset();
    tick();
    tick();
    fif.dec_ready = 1'b1;
    redirect_en   = 1'b1;
    redirect_pc   = 64'h100;
    tick();
    redirect_en = 1'b0;
    if (fif.f_valid !== 1'b0) $display("FAIL redir_flush got %h exp %h", fif.f_valid, 1'b0); else pass_cnt++;
    total_cnt++;
    if (imem_pc !== 64'h100) $display("FAIL redir_imem_pc got %h exp %h", imem_pc, 64'h100); else pass_cnt++;
    total_cnt++;
    tick();
    if (fif.f_valid !== 1'b1) $display("FAIL redir_valid got %h exp %h", fif.f_valid, 1'b1); else pass_cnt++;
    total_cnt++;
    if (fif.f_pc !== 64'h100) $display("FAIL redir_pc got %h exp %h", fif.f_pc, 64'h100); else pass_cnt++;
    total_cnt++;
    tick();
    if (fif.f_pc !== 64'h104) $display("FAIL redir_next got %h exp %h", fif.f_pc, 64'h104); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_imem_exc();
    fif.dec_ready = 1'b1;
    do_reset();
    exc_arm     = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 64'h2000;
    tick();
    redirect_en = 1'b0;
    tick();
    if ({fif.f_valid, fif.f_exc_en, fif.f_exc_code} !== 6'b11_0001)
      $display("FAIL exc_flags got %b exp %b", {fif.f_valid, fif.f_exc_en, fif.f_exc_code}, 6'b11_0001);
    else pass_cnt++;
    total_cnt++;
    if (fif.f_exc_val !== 64'h2000) $display("FAIL exc_val got %h exp %h", fif.f_exc_val, 64'h2000); else pass_cnt++;
    total_cnt++;
    if (fif.f_instr !== 32'h13) $display("FAIL exc_instr got %h exp %h", fif.f_instr, 32'h13); else pass_cnt++;
    total_cnt++;
    if (imem_pc !== 64'h2000) $display("FAIL exc_pc_hold got %h exp %h", imem_pc, 64'h2000); else pass_cnt++;
    total_cnt++;
    tick();
    tick();
    if (fif.f_valid !== 1'b0) $display("FAIL halt_no_push got %h exp %h", fif.f_valid, 1'b0); else pass_cnt++;
    total_cnt++;
    if (imem_pc !== 64'h2000) $display("FAIL halt_pc got %h exp %h", imem_pc, 64'h2000); else pass_cnt++;
    total_cnt++;
    if (fif.f_exc_en !== 1'b1) $display("FAIL halt_hold_fields got %h exp %h", fif.f_exc_en, 1'b1); else pass_cnt++;
    total_cnt++;
    redirect_en = 1'b1;
    redirect_pc = 64'h80;
    tick();
    redirect_en = 1'b0;
    tick();
    if ({fif.f_valid, fif.f_exc_en} !== 2'b10) $display("FAIL restart_flags got %b exp %b", {fif.f_valid, fif.f_exc_en}, 2'b10); else pass_cnt++;
    total_cnt++;
    if (fif.f_pc !== 64'h80) $display("FAIL restart_pc got %h exp %h", fif.f_pc, 64'h80); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_misaligned_and_reset();
    fif.dec_ready = 1'b0;
    do_reset();
    redirect_en = 1'b1;
    redirect_pc = 64'h102;
    tick();
    redirect_en = 1'b0;
    tick();
    if ({fif.f_valid, fif.f_exc_en, fif.f_exc_code} !== 6'b11_0000)
      $display("FAIL mis_flags got %b exp %b", {fif.f_valid, fif.f_exc_en, fif.f_exc_code}, 6'b11_0000);
    else pass_cnt++;
    total_cnt++;
    if (fif.f_exc_val !== 64'h102) $display("FAIL mis_val got %h exp %h", fif.f_exc_val, 64'h102); else pass_cnt++;
    total_cnt++;
    if (fif.f_instr !== 32'h13) $display("FAIL mis_instr got %h exp %h", fif.f_instr, 32'h13); else pass_cnt++;
    total_cnt++;
    tick();
    fif.dec_ready = 1'b1;
    tick();
    if (fif.f_valid !== 1'b0) $display("FAIL mis_single got %h exp %h", fif.f_valid, 1'b0); else pass_cnt++;
    total_cnt++;
    redirect_en = 1'b1;
    redirect_pc = 64'h40;
    tick();
    redirect_en = 1'b0;
    tick();
    tick();
    if (fif.f_pc !== 64'h44) $display("FAIL pre_rst_pc got %h exp %h", fif.f_pc, 64'h44); else pass_cnt++;
    total_cnt++;
    #3 rst_n = 1'b0;
    #1;
    if (fif.f_valid !== 1'b0) $display("FAIL async_rst_valid got %h exp %h", fif.f_valid, 1'b0); else pass_cnt++;
    total_cnt++;
    if (imem_pc !== 64'h0) $display("FAIL async_rst_pc got %h exp %h", imem_pc, 64'h0); else pass_cnt++;
    total_cnt++;
    if (fif.f_instr !== 32'h13) $display("FAIL async_rst_instr got %h exp %h", fif.f_instr, 32'h13); else pass_cnt++;
    total_cnt++;
    rst_n = 1'b1;
    tick();
    if ({fif.f_valid, fif.f_pc} !== {1'b1, 64'h0}) $display("FAIL post_rst_push got %h exp %h", {fif.f_valid, fif.f_pc}, {1'b1, 64'h0}); else pass_cnt++;
    total_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_stream();
    test_stall_and_full();
    test_redirect();
    test_imem_exc();
    test_misaligned_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the PC loaded on reset.
REQ-002 Parameter DEPTH, default 2, is the number of fetch-queue entries; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_pc  output  64  fetch address driven to the instruction memory; equals the internal PC register.
REQ-006 imem_instr  input  32  instruction returned combinationally for imem_pc.
REQ-007 imem_exc_en  input  1  instruction memory reports an access fault for imem_pc.
REQ-008 imem_exc_code  input  4  memory fault cause.
REQ-009 imem_exc_val  input  64  memory fault tval.
REQ-010 redirect_en  input  1  branch, jump or trap redirect request.
REQ-011 redirect_pc  input  64  new fetch PC when redirect_en is 1.
REQ-012 dec_ready  input  1  decode accepts the head entry this cycle.
REQ-013 f_valid  output  1  head entry is valid.
REQ-014 f_pc, f_instr  output  64, 32  head entry PC and instruction word.
REQ-015 f_exc_en, f_exc_code, f_exc_val  output  1, 4, 64  head entry exception fields.

Function
REQ-016 The FSM SHALL have two states: FETCH (issue fetches) and HALT (exception entry queued; no fetch).
REQ-017 Pop SHALL occur when f_valid and dec_ready are both 1 and redirect_en is 0.
REQ-018 In FETCH, push SHALL occur when redirect_en is 0 and the queue holds fewer than DEPTH entries or a pop occurs in the same cycle (push into full queue with simultaneous pop is allowed).
REQ-019 A push SHALL write {PC, imem_instr, exception fields} at the tail pointer and advance PC by 4, modulo 2^64.
REQ-020 If PC[1:0] != 0, the pushed entry SHALL carry exc_en=1, exc_code=0, exc_val=PC and instr=32'h00000013, overriding imem inputs.
REQ-021 Otherwise, if imem_exc_en=1, the pushed entry SHALL carry imem_exc_code and imem_exc_val with instr=32'h00000013.
REQ-022 Pushing any entry with exc_en=1 SHALL move FETCH->HALT and SHALL NOT advance PC.
REQ-023 In HALT, no push SHALL occur; pops continue until the queue is empty; HALT persists until redirect.
REQ-024 redirect_en=1 SHALL, on that edge, flush all entries (count=0, pointers=0), load PC with redirect_pc and enter FETCH; it takes priority over push and pop in the same cycle.
REQ-025 First fetch after redirect SHALL be pushed on the cycle after redirect_en (one-cycle redirect bubble).
REQ-026 Head and tail pointers SHALL wrap from DEPTH-1 to 0; occupancy counter ranges 0..DEPTH.
REQ-027 f_valid SHALL equal (count != 0); f_* fields SHALL come from the head entry registers, with no combinational path from imem inputs to f_* outputs.
REQ-028 When f_valid=0, f_pc, f_instr and exception fields SHALL hold their last values; they are don't-care for decode.
REQ-029 Latency: a fetch pushed at edge N SHALL appear at f_* after edge N when the queue was empty.

Reset
REQ-030 On rst_n=0, immediately and independent of clk: PC=RESET_PC, state=FETCH, count=0, pointers=0, f_valid=0, f_pc=0, f_instr=32'h00000013, f_exc_en=0, f_exc_code=0, f_exc_val=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries and any pending HALT.
REQ-032 First push after rst_n release SHALL occur on the first rising clk edge with rst_n=1.

Verification
REQ-033 Reset release, dec_ready=1, imem returns distinct words -> f_valid rises after edge 1 with f_pc=0, then f_pc=4, 8, 12 on consecutive cycles.
REQ-034 dec_ready=0 for 5 cycles -> queue fills to 2 entries (f_pc=0 held), imem_pc stalls at 8; dec_ready=1 -> f_pc 0, 4, 8 in order, no loss or duplication.
REQ-035 Queue full, dec_ready=1 -> push and pop same cycle, count stays 2, throughput one per cycle.
REQ-036 redirect_en=1, redirect_pc=0x100 with 2 entries queued and dec_ready=1 -> next cycle f_valid=0, following cycle f_pc=0x100; flushed entries never reach decode.
REQ-037 imem_exc_en=1, code=1, val=0x2000 at PC=0x2000 -> entry f_exc_en=1, f_exc_code=1, f_exc_val=0x2000, f_instr=32'h00000013; imem_pc stays 0x2000; no further pushes until redirect_pc=0x80 restarts fetch.
REQ-038 redirect_pc=0x102 -> one entry with f_exc_en=1, f_exc_code=0, f_exc_val=0x102, then HALT; rst_n pulsed low mid-stream -> f_valid=0 immediately, imem_pc=RESET_PC.
